// File: rtl/axi_lite_slave.sv
// rtl/axi_lite_slave.sv - AXI4-Lite slave backed by a small byte-writable register file
//
// Purpose: a single-clock AXI4-Lite slave with MEM_DEPTH 32-bit words of
// storage. The write side uses a 4-state FSM that accepts AW and W in any
// order. The read side uses a 2-state FSM. The two FSMs run concurrently.
//
// Ports:
//   aclk, areset_n              clock; asynchronous active-low reset
//   awaddr/awvalid/awready      write address channel
//   wdata/wstrb/wvalid/wready   write data channel
//   bresp/bvalid/bready         write response channel
//   araddr/arvalid/arready      read address channel
//   rdata/rresp/rvalid/rready   read data channel
module axi_lite_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 32
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_HAVE_ADDR = 2'd1;
    localparam logic [1:0] W_HAVE_DATA = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [1:0]            w_state;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic [1:0]            bresp_q;

    logic [0:0]            r_state;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Ready signals are pure functions of FSM state, never of valid.
    assign awready = (w_state == W_IDLE) || (w_state == W_HAVE_DATA);
    assign wready  = (w_state == W_IDLE) || (w_state == W_HAVE_ADDR);
    assign bvalid  = (w_state == W_RESP);
    assign bresp   = bresp_q;

    assign arready = (r_state == R_IDLE);
    assign rvalid  = (r_state == R_DATA);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    logic aw_hs, w_hs, ar_hs;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // The edge that completes the address+data pair. The half that arrived
    // earlier comes from its latch. The half arriving now comes from the bus.
    logic                  commit;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]     c_strb;
    logic                  c_in_range;
    logic [IDX_W-1:0]      c_idx;

    assign commit = ((w_state == W_IDLE)      && aw_hs && w_hs) ||
                    ((w_state == W_HAVE_ADDR) && w_hs) ||
                    ((w_state == W_HAVE_DATA) && aw_hs);
    assign c_addr     = (w_state == W_HAVE_ADDR) ? aw_addr_q : awaddr;
    assign c_data     = (w_state == W_HAVE_DATA) ? w_data_q  : wdata;
    assign c_strb     = (w_state == W_HAVE_DATA) ? w_strb_q  : wstrb;
    assign c_in_range = (c_addr < MEM_BYTES);
    assign c_idx      = c_addr[2 +: IDX_W];

    logic             ar_in_range;
    logic [IDX_W-1:0] ar_idx;
    assign ar_in_range = (araddr < MEM_BYTES);
    assign ar_idx      = araddr[2 +: IDX_W];

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else if (commit) begin
            w_state <= W_RESP;
            bresp_q <= c_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if ((w_state == W_IDLE) && aw_hs) begin
            w_state   <= W_HAVE_ADDR;
            aw_addr_q <= awaddr;
        end else if ((w_state == W_IDLE) && w_hs) begin
            w_state  <= W_HAVE_DATA;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
        end else if ((w_state == W_RESP) && bready) begin
            w_state <= W_IDLE;
        end
    end

    // Storage clears on reset. A reset during a transaction therefore
    // cannot leave a partial write behind.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (commit && c_in_range) begin
            for (int b = 0; b < STRB_W; b++)
                if (c_strb[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
        end
    end

    // A read sampled on the same edge as a commit sees the pre-write word.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            r_state <= R_DATA;
            rdata_q <= ar_in_range ? mem[ar_idx] : '0;
            rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if ((r_state == R_DATA) && rready) begin
            r_state <= R_IDLE;
        end
    end
endmodule

// File: tb/tb_axi_lite_slave.sv
// tb/tb_axi_lite_slave.sv - self-checking bench for axi_lite_slave
module tb_axi_lite_slave;
    logic        aclk = 1'b0;
    logic        areset_n;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axi_lite_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;   // 0: AW+W together, 1: W then AW 3 cycles later, 2: AW then W
        logic [1:0]  bresp;
        logic [31:0] rdata;  // readback of addr afterwards
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: responses are popped and compared as the DUT presents them.
    always @(negedge aclk) begin
        if (areset_n && bvalid && bready) begin
            if (bq.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got bresp %h with nothing pending", bresp);
            end else begin
                check("bresp", 32'(bresp), 32'(bq.pop_front()));
            end
        end
        if (areset_n && rvalid && rready) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL r_unexpected: got rdata %h with nothing pending", rdata);
            end else begin
                logic [33:0] e;
                e = rq.pop_front();
                check("rdata", rdata, e[33:2]);
                check("rresp", 32'(rresp), 32'(e[1:0]));
            end
        end
    end

    task automatic wait_b_idle();
        for (int n = 0; n < 20 && bvalid; n++) @(negedge aclk);
        check("b_done", 32'(bvalid), 32'd0);
    endtask

    task automatic wait_r_idle();
        for (int n = 0; n < 20 && rvalid; n++) @(negedge aclk);
        check("r_done", 32'(rvalid), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int mode, input logic [1:0] exp_resp);
        @(negedge aclk);
        if (mode == 1) begin
            wdata = d; wstrb = s; wvalid = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            wvalid = 1'b0;
            check("have_data_awready", 32'(awready), 32'd1);
            check("have_data_wready", 32'(wready), 32'd0);
            @(negedge aclk);
            @(negedge aclk);
            awaddr = a; awvalid = 1'b1;
        end else if (mode == 2) begin
            awaddr = a; awvalid = 1'b1;
            @(posedge aclk);
            @(negedge aclk);
            awvalid = 1'b0;
            check("have_addr_awready", 32'(awready), 32'd0);
            check("have_addr_wready", 32'(wready), 32'd1);
            wdata = d; wstrb = s; wvalid = 1'b1;
        end else begin
            awaddr = a; awvalid = 1'b1;
            wdata = d; wstrb = s; wvalid = 1'b1;
        end
        @(posedge aclk);
        bq.push_back(exp_resp);
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("b_latency", 32'(bvalid), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        @(negedge aclk);
        araddr = a; arvalid = 1'b1;
        @(posedge aclk);
        rq.push_back({exp_d, exp_r});
        @(negedge aclk);
        arvalid = 1'b0;
        check("r_latency", 32'(rvalid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h08,  32'hDEADBEEF, 4'hF, 0, 2'b00, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{32'h0C,  32'hAABBCCDD, 4'hF, 0, 2'b00, 32'hAABBCCDD, 2'b00};
        vecs[2] = '{32'h0C,  32'h11223344, 4'h3, 1, 2'b00, 32'hAABB3344, 2'b00};
        vecs[3] = '{32'h10,  32'h55667788, 4'hC, 2, 2'b00, 32'h55660000, 2'b00};
        vecs[4] = '{32'h13,  32'h000000AA, 4'h1, 0, 2'b00, 32'h556600AA, 2'b00};
        vecs[5] = '{32'h10,  32'hFFFFFFFF, 4'h0, 0, 2'b00, 32'h556600AA, 2'b00};
        vecs[6] = '{32'h80,  32'h12345678, 4'hF, 0, 2'b10, 32'h00000000, 2'b10};
        vecs[7] = '{32'h7C,  32'hCAFEF00D, 4'hF, 2, 2'b00, 32'hCAFEF00D, 2'b00};
        vecs[8] = '{32'h100, 32'h12345678, 4'hF, 1, 2'b10, 32'h00000000, 2'b10};
        vecs[9] = '{32'h00,  32'h01020304, 4'h0, 0, 2'b00, 32'h00000000, 2'b00};

        areset_n = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
        araddr = '0; arvalid = 0; rready = 1;
        repeat (2) @(negedge aclk);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        areset_n = 1'b1;

        do_read(32'h4, 32'h0, 2'b00);
        wait_r_idle();

        for (int i = 0; i < 10; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].mode, vecs[i].bresp);
            wait_b_idle();
            do_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp);
            wait_r_idle();
        end

        // Response stall: bvalid/bresp hold and a competing write is refused.
        @(posedge aclk); #1 bready = 1'b0;
        do_write(32'h14, 32'h0BADF00D, 4'hF, 0, 2'b00);
        awaddr = 32'h14; awvalid = 1'b1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            check("stall_bvalid", 32'(bvalid), 32'd1);
            check("stall_bresp", 32'(bresp), 32'd0);
            check("stall_awready", 32'(awready), 32'd0);
            check("stall_wready", 32'(wready), 32'd0);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        @(posedge aclk); #1 bready = 1'b1;
        wait_b_idle();
        do_read(32'h14, 32'h0BADF00D, 2'b00);
        wait_r_idle();

        // Read stall: rdata held while rready is low.
        @(posedge aclk); #1 rready = 1'b0;
        do_read(32'h08, 32'hDEADBEEF, 2'b00);
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            check("rstall_rdata", rdata, 32'hDEADBEEF);
            check("rstall_arready", 32'(arready), 32'd0);
        end
        @(posedge aclk); #1 rready = 1'b1;
        wait_r_idle();

        // Read and write commit to the same word on one edge.
        @(negedge aclk);
        awaddr = 32'h18; awvalid = 1; wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1;
        araddr = 32'h18; arvalid = 1;
        @(posedge aclk);
        bq.push_back(2'b00);
        rq.push_back({32'h0, 2'b00});
        @(negedge aclk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        wait_b_idle();
        wait_r_idle();
        do_read(32'h18, 32'h77777777, 2'b00);
        wait_r_idle();

        // Reset while holding only a write address.
        @(negedge aclk);
        awaddr = 32'h1C; awvalid = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        awvalid = 1'b0;
        check("mid_awready", 32'(awready), 32'd0);
        areset_n = 1'b0;
        #1;
        check("mid_rst_awready", 32'(awready), 32'd1);
        check("mid_rst_wready", 32'(wready), 32'd1);
        check("mid_rst_bvalid", 32'(bvalid), 32'd0);
        @(negedge aclk);
        areset_n = 1'b1;
        do_read(32'h1C, 32'h0, 2'b00);
        wait_r_idle();
        do_read(32'h08, 32'h0, 2'b00);
        wait_r_idle();

        check("b_pending", 32'(bq.size()), 32'd0);
        check("r_pending", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
